fabric_mem_resp: RTL and testbench

Memory-side responder for the fabric controller's map/direction memory interface. It services the controller's read requests against a 128-word map bank at MAP_BASE and its write requests against a 128-word direction bank at DIR_BASE. It returns read data with a fixed-latency `data_rdy` pulse and accepts a new request every cycle, including the cycle in which data is returned. A host-side port fills the map bank, reads back the direction bank, and can launch a hardware clear of the direction bank.

---
 rtl/fabric_mem_resp_pkg.sv | 27 ++
 rtl/fabric_word_bank.sv | 31 +++
 rtl/fabric_mem_resp.sv | 250 +++++++++++++++++++++++++
 tb/tb_fabric_mem_resp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_mem_resp_pkg.sv
// Shared fabric definitions: bank base addresses, the error read pattern,
// the bank-select encoding and the clear-engine state encoding.
package fabric_mem_resp_pkg;

   localparam int          DATA_W          = 32;
   localparam logic [31:0] FAB_MAP_BASE    = 32'h4000_0000;
   localparam logic [31:0] FAB_DIR_BASE    = 32'h4000_2000;
   localparam logic [31:0] FAB_ERR_PATTERN = 32'hDEAD_BEEF;

   typedef enum logic {
      BANK_MAP = 1'b0,
      BANK_DIR = 1'b1
   } bank_e;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   // Byte offset of an address from a bank base (wraps for addresses below base,
   // which then land far out of range).
   function automatic logic [31:0] bank_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/fabric_word_bank.sv
// Single-port synchronous word RAM, read-first: a read and write to the same
// word in one cycle returns the old contents. Contents are not reset.
module fabric_word_bank
   import fabric_mem_resp_pkg::*;
#(
   parameter int WORDS = 128
) (
   input  logic                     clk,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [$clog2(WORDS)-1:0] addr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   output logic [DATA_W-1:0]        rdata_o
);

   logic [DATA_W-1:0] mem_q [WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Array access: capture old word, then optionally overwrite it
   always_ff @(posedge clk) begin
      if (en_i) begin
         rdata_q <= mem_q[addr_i];
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fabric_mem_resp.sv
// Memory-side responder for the fabric controller: fabric reads hit the map
// bank through a fixed-latency pipeline, fabric writes hit the direction bank,
// a host port shares both banks at lowest priority, and a clear engine zeroes
// the direction bank in the background.
module fabric_mem_resp
   import fabric_mem_resp_pkg::*;
#(
   parameter logic [31:0] MAP_BASE = FAB_MAP_BASE,
   parameter logic [31:0] DIR_BASE = FAB_DIR_BASE,
   parameter int          WORDS    = 128,
   parameter int          RD_LAT   = 2
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        req_rd,
   input  logic [31:0] addr_rd,
   output logic [31:0] data_rd,
   output logic        data_rdy,
   input  logic        req_wr,
   input  logic [31:0] addr_wr,
   input  logic [31:0] data_wr,
   output logic        wr_ack,
   input  logic        host_we,
   input  logic        host_re,
   input  logic        host_sel,
   input  logic [6:0]  host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        host_rvalid,
   output logic        host_stall,
   input  logic        host_clr_dir,
   output logic        busy,
   output logic        err
);

   localparam int            IW       = $clog2(WORDS);
   localparam logic [31:0]   SPAN     = 32'(4 * WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   // ---------------------------------------------------------------- decode
   logic [31:0]   rd_offs, wr_offs;
   logic          rd_in_range, wr_in_range;
   logic          fab_rd_map, fab_wr_dir;
   logic          rd_err, wr_err;
   logic [IW-1:0] rd_idx, wr_idx, host_idx;

   assign rd_offs     = bank_offset(addr_rd, MAP_BASE);
   assign wr_offs     = bank_offset(addr_wr, DIR_BASE);
   assign rd_in_range = (rd_offs < SPAN);
   assign wr_in_range = (wr_offs < SPAN);
   assign rd_idx      = rd_offs[IW+1:2];
   assign wr_idx      = wr_offs[IW+1:2];
   assign host_idx    = host_addr[IW-1:0];

   // Misaligned in-range reads still use the map bank (truncated index);
   // writes only land when aligned and inside the dir bank.
   assign fab_rd_map  = req_rd & rd_in_range;
   assign fab_wr_dir  = req_wr & wr_in_range & (addr_wr[1:0] == 2'b00);
   assign rd_err      = req_rd & (~rd_in_range | (addr_rd[1:0] != 2'b00));
   assign wr_err      = req_wr & ~fab_wr_dir;

   // ---------------------------------------------------------- clear engine
   clr_state_e    clr_state_q, clr_state_d;
   logic [IW-1:0] clr_cnt_q, clr_cnt_d;
   logic          clr_we;

   // Clear FSM state and word counter
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         clr_state_q <= CLR_IDLE;
         clr_cnt_q   <= '0;
      end else begin
         clr_state_q <= clr_state_d;
         clr_cnt_q   <= clr_cnt_d;
      end
   end

   // Clear FSM next state: a fabric dir write steals the bank and holds the counter
   always_comb begin
      clr_state_d = clr_state_q;
      clr_cnt_d   = clr_cnt_q;
      clr_we      = 1'b0;
      case (clr_state_q)
         CLR_IDLE: begin
            if (host_clr_dir) begin
               clr_cnt_d   = '0;
               clr_state_d = CLR_RUN;
            end
         end
         CLR_RUN: begin
            clr_we = ~fab_wr_dir;
            if (host_clr_dir) begin
               clr_cnt_d = '0;
            end else if (clr_we) begin
               if (clr_cnt_q == LAST_IDX) begin
                  clr_cnt_d   = '0;
                  clr_state_d = CLR_IDLE;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            clr_state_d = CLR_IDLE;
         end
      endcase
   end

   assign busy = (clr_state_q == CLR_RUN);

   // ----------------------------------------------------------- arbitration
   bank_e host_bank;
   logic  host_strobe, host_go, map_taken, dir_taken;
   logic  host_map_go, host_dir_go;

   assign host_bank   = bank_e'(host_sel);
   assign host_strobe = host_we | host_re;
   assign map_taken   = fab_rd_map;
   assign dir_taken   = fab_wr_dir | busy;
   assign host_stall  = host_strobe & ((host_bank == BANK_DIR) ? dir_taken : map_taken);
   assign host_go     = host_strobe & ~host_stall;
   assign host_map_go = host_go & (host_bank == BANK_MAP);
   assign host_dir_go = host_go & (host_bank == BANK_DIR);

   // ----------------------------------------------------------------- banks
   logic          map_en, map_we, dir_en, dir_we;
   logic [IW-1:0] map_addr, dir_addr;
   logic [31:0]   dir_wdata, map_rdata, dir_rdata;

   assign map_en    = fab_rd_map | host_map_go;
   assign map_we    = host_map_go & host_we;
   assign map_addr  = fab_rd_map ? rd_idx : host_idx;

   assign dir_en    = fab_wr_dir | clr_we | host_dir_go;
   assign dir_we    = fab_wr_dir | clr_we | (host_dir_go & host_we);
   assign dir_addr  = fab_wr_dir ? wr_idx  : (clr_we ? clr_cnt_q : host_idx);
   assign dir_wdata = fab_wr_dir ? data_wr : (clr_we ? 32'h0     : host_wdata);

   fabric_word_bank #(.WORDS(WORDS)) u_map_bank (
      .clk     (clk),
      .en_i    (map_en),
      .we_i    (map_we),
      .addr_i  (map_addr),
      .wdata_i (host_wdata),
      .rdata_o (map_rdata)
   );

   fabric_word_bank #(.WORDS(WORDS)) u_dir_bank (
      .clk     (clk),
      .en_i    (dir_en),
      .we_i    (dir_we),
      .addr_i  (dir_addr),
      .wdata_i (dir_wdata),
      .rdata_o (dir_rdata)
   );

   // ------------------------------------------ p1: bank output / error flags
   logic        rd_vld_p1_q, rd_bad_p1_q;
   logic        hrd_vld_p1_q;
   bank_e       hrd_bank_p1_q;
   logic [31:0] rd_dat_p1;
   logic        wr_ack_q, err_q;

   // Control state: request valids, write ack and sticky error
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_vld_p1_q  <= 1'b0;
         hrd_vld_p1_q <= 1'b0;
         wr_ack_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rd_vld_p1_q  <= req_rd;
         hrd_vld_p1_q <= host_re & host_go;
         wr_ack_q     <= req_wr;
         err_q        <= (host_clr_dir ? 1'b0 : err_q) | rd_err | wr_err;
      end
   end

   // Per-request attributes travelling beside the valids
   always_ff @(posedge clk) begin
      rd_bad_p1_q   <= ~rd_in_range;
      hrd_bank_p1_q <= host_bank;
   end

   assign rd_dat_p1 = rd_bad_p1_q ? FAB_ERR_PATTERN : map_rdata;
   assign wr_ack    = wr_ack_q;
   assign err       = err_q;

   // ------------------------------------------- p2..pRD_LAT: delay pipeline
   logic        out_vld;
   logic [31:0] out_dat;

   if (RD_LAT == 1) begin : g_lat1
      assign out_vld = rd_vld_p1_q;
      assign out_dat = rd_dat_p1;
   end else begin : g_latn
      logic [RD_LAT-2:0]       vld_pn_q;
      logic [RD_LAT-2:0][31:0] dat_pn_q;

      // Valid shift register; reset discards reads in flight
      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) begin
            vld_pn_q <= '0;
         end else begin
            vld_pn_q[0] <= rd_vld_p1_q;
            for (int i = 1; i < RD_LAT - 1; i++) begin
               vld_pn_q[i] <= vld_pn_q[i-1];
            end
         end
      end

      // Data shift register alongside the valids
      always_ff @(posedge clk) begin
         dat_pn_q[0] <= rd_dat_p1;
         for (int i = 1; i < RD_LAT - 1; i++) begin
            dat_pn_q[i] <= dat_pn_q[i-1];
         end
      end

      assign out_vld = vld_pn_q[RD_LAT-2];
      assign out_dat = dat_pn_q[RD_LAT-2];
   end

   // ---------------------------------------------------------- output hold
   logic [31:0] rd_hold_q, hrd_hold_q;
   logic [31:0] hrd_dat_p1;

   assign hrd_dat_p1 = (hrd_bank_p1_q == BANK_DIR) ? dir_rdata : map_rdata;

   // Last delivered read values, shown while the completion pulses are low
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_hold_q  <= '0;
         hrd_hold_q <= '0;
      end else begin
         if (out_vld) begin
            rd_hold_q <= out_dat;
         end
         if (hrd_vld_p1_q) begin
            hrd_hold_q <= hrd_dat_p1;
         end
      end
   end

   assign data_rdy    = out_vld;
   assign data_rd     = out_vld ? out_dat : rd_hold_q;
   assign host_rvalid = hrd_vld_p1_q;
   assign host_rdata  = hrd_vld_p1_q ? hrd_dat_p1 : hrd_hold_q;

endmodule

// File: tb/tb_fabric_mem_resp.sv
// Directed bench for fabric_mem_resp: a vector table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_fabric_mem_resp;

   logic        clk;
   logic        arst_n;
   logic        req_rd;
   logic [31:0] addr_rd;
   logic [31:0] data_rd;
   logic        data_rdy;
   logic        req_wr;
   logic [31:0] addr_wr;
   logic [31:0] data_wr;
   logic        wr_ack;
   logic        host_we;
   logic        host_re;
   logic        host_sel;
   logic [6:0]  host_addr;
   logic [31:0] host_wdata;
   logic [31:0] host_rdata;
   logic        host_rvalid;
   logic        host_stall;
   logic        host_clr_dir;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   fabric_mem_resp dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .req_rd       (req_rd),
      .addr_rd      (addr_rd),
      .data_rd      (data_rd),
      .data_rdy     (data_rdy),
      .req_wr       (req_wr),
      .addr_wr      (addr_wr),
      .data_wr      (data_wr),
      .wr_ack       (wr_ack),
      .host_we      (host_we),
      .host_re      (host_re),
      .host_sel     (host_sel),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_rdata   (host_rdata),
      .host_rvalid  (host_rvalid),
      .host_stall   (host_stall),
      .host_clr_dir (host_clr_dir),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   typedef enum int {OP_HWR, OP_HRD, OP_FRD, OP_FWR} op_e;
   typedef struct {
      op_e         op;
      logic        sel;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;

   vec_t vt [19];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      case (v.op)
         OP_HWR: begin
            host_we = 1'b1; host_sel = v.sel; host_addr = v.addr[6:0]; host_wdata = v.data;
            #1 chk1($sformatf("v%0d_hwr_stall", i), host_stall, 1'b0);
            tick();
            host_we = 1'b0;
         end
         OP_HRD: begin
            host_re = 1'b1; host_sel = v.sel; host_addr = v.addr[6:0];
            #1 chk1($sformatf("v%0d_hrd_stall", i), host_stall, 1'b0);
            tick();
            host_re = 1'b0;
            chk1($sformatf("v%0d_hrd_rvalid", i), host_rvalid, 1'b1);
            chk32($sformatf("v%0d_hrd_rdata", i), host_rdata, v.exp);
            chk1($sformatf("v%0d_hrd_err", i), err, v.exp_err);
         end
         OP_FRD: begin
            req_rd = 1'b1; addr_rd = v.addr;
            tick();
            req_rd = 1'b0;
            chk1($sformatf("v%0d_frd_early_rdy", i), data_rdy, 1'b0);
            tick();
            chk1($sformatf("v%0d_frd_rdy", i), data_rdy, 1'b1);
            chk32($sformatf("v%0d_frd_data", i), data_rd, v.exp);
            chk1($sformatf("v%0d_frd_err", i), err, v.exp_err);
         end
         OP_FWR: begin
            req_wr = 1'b1; addr_wr = v.addr; data_wr = v.data;
            tick();
            req_wr = 1'b0;
            chk1($sformatf("v%0d_fwr_ack", i), wr_ack, 1'b1);
            chk1($sformatf("v%0d_fwr_err", i), err, v.exp_err);
         end
         default: ;
      endcase
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk32({tag, "_data_rd"}, data_rd, 32'h0);
      chk1({tag, "_data_rdy"}, data_rdy, 1'b0);
      chk1({tag, "_wr_ack"}, wr_ack, 1'b0);
      chk32({tag, "_host_rdata"}, host_rdata, 32'h0);
      chk1({tag, "_host_rvalid"}, host_rvalid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      int  busy_n;
      bit  done;
      bit  rdy_seen;

      arst_n = 1'b0; req_rd = 1'b0; addr_rd = '0; req_wr = 1'b0; addr_wr = '0; data_wr = '0;
      host_we = 1'b0; host_re = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
      host_clr_dir = 1'b0;

      //            op      sel   addr/idx        data           expected       err
      vt[0]  = '{OP_HWR, 1'b0, 32'd0,          32'h76543210, 32'h0,          1'b0};
      vt[1]  = '{OP_HWR, 1'b0, 32'd1,          32'hFEDCBA98, 32'h0,          1'b0};
      vt[2]  = '{OP_HWR, 1'b0, 32'd4,          32'h00004444, 32'h0,          1'b0};
      vt[3]  = '{OP_FRD, 1'b0, 32'h40000000,   32'h0,        32'h76543210,   1'b0};
      vt[4]  = '{OP_FRD, 1'b0, 32'h40000004,   32'h0,        32'hFEDCBA98,   1'b0};
      vt[5]  = '{OP_FRD, 1'b0, 32'h40000010,   32'h0,        32'h00004444,   1'b0};
      vt[6]  = '{OP_FWR, 1'b0, 32'h40002008,   32'h00000ABC, 32'h0,          1'b0};
      vt[7]  = '{OP_HRD, 1'b1, 32'd2,          32'h0,        32'h00000ABC,   1'b0};
      vt[8]  = '{OP_FWR, 1'b0, 32'h400021FC,   32'h0000CAFE, 32'h0,          1'b0};
      vt[9]  = '{OP_HRD, 1'b1, 32'd127,        32'h0,        32'h0000CAFE,   1'b0};
      vt[10] = '{OP_HRD, 1'b0, 32'd1,          32'h0,        32'hFEDCBA98,   1'b0};
      vt[11] = '{OP_FRD, 1'b0, 32'h40000200,   32'h0,        32'hDEADBEEF,   1'b1};
      vt[12] = '{OP_FWR, 1'b0, 32'h40000000,   32'h00000055, 32'h0,          1'b1};
      vt[13] = '{OP_HRD, 1'b0, 32'd0,          32'h0,        32'h76543210,   1'b1};
      vt[14] = '{OP_FWR, 1'b0, 32'h4000200A,   32'h00000099, 32'h0,          1'b1};
      vt[15] = '{OP_HRD, 1'b1, 32'd2,          32'h0,        32'h00000ABC,   1'b1};
      vt[16] = '{OP_FRD, 1'b0, 32'h40000006,   32'h0,        32'hFEDCBA98,   1'b1};
      vt[17] = '{OP_FRD, 1'b0, 32'h3FFFFFFC,   32'h0,        32'hDEADBEEF,   1'b1};
      vt[18] = '{OP_FWR, 1'b0, 32'h40002200,   32'h00000011, 32'h0,          1'b1};

      // Reset state
      tick(); tick();
      chk_reset_outputs("rst");
      chk1("rst_host_stall", host_stall, 1'b0);
      arst_n = 1'b1;
      tick();

      for (int i = 0; i < 19; i++) begin
         run_vec(i, vt[i]);
      end

      // Back-to-back reads complete on consecutive cycles, in order
      req_rd = 1'b1; addr_rd = 32'h40000000;
      tick();
      addr_rd = 32'h40000004;
      chk1("b2b_c1_rdy", data_rdy, 1'b0);
      tick();
      req_rd = 1'b0;
      chk1("b2b_c2_rdy", data_rdy, 1'b1);
      chk32("b2b_c2_data", data_rd, 32'h76543210);
      tick();
      chk1("b2b_c3_rdy", data_rdy, 1'b1);
      chk32("b2b_c3_data", data_rd, 32'hFEDCBA98);
      tick();
      chk1("b2b_c4_rdy", data_rdy, 1'b0);
      chk32("b2b_c4_hold", data_rd, 32'hFEDCBA98);

      // Host map read colliding with a fabric map read stalls, then retries
      req_rd = 1'b1; addr_rd = 32'h40000000;
      host_re = 1'b1; host_sel = 1'b0; host_addr = 7'd4;
      #1 chk1("coll_stall", host_stall, 1'b1);
      tick();
      req_rd = 1'b0;
      chk1("coll_no_rvalid", host_rvalid, 1'b0);
      #1 chk1("retry_stall", host_stall, 1'b0);
      tick();
      host_re = 1'b0;
      chk1("retry_rvalid", host_rvalid, 1'b1);
      chk32("retry_rdata", host_rdata, 32'h00004444);
      chk1("coll_fab_rdy", data_rdy, 1'b1);
      chk32("coll_fab_data", data_rd, 32'h76543210);

      // Same-cycle host read and write of one word returns the old data
      host_we = 1'b1; host_re = 1'b1; host_sel = 1'b0; host_addr = 7'd4; host_wdata = 32'h00004545;
      tick();
      host_we = 1'b0; host_re = 1'b0;
      chk32("rfirst_old", host_rdata, 32'h00004444);
      host_re = 1'b1;
      tick();
      host_re = 1'b0;
      chk32("rfirst_new", host_rdata, 32'h00004545);

      // Clear with a fabric dir write stealing one cycle
      host_clr_dir = 1'b1;
      chk1("clr_pre_err", err, 1'b1);
      tick();
      host_clr_dir = 1'b0;
      busy_n = 0;
      done   = 1'b0;
      for (int t = 1; t < 400; t++) begin
         if (!busy) begin
            done = 1'b1;
            break;
         end
         busy_n++;
         if (t == 3) begin
            req_wr = 1'b1; addr_wr = 32'h40002014; data_wr = 32'h00000077;
         end
         if (t == 4) req_wr = 1'b0;
         if (t == 5) begin
            host_re = 1'b1; host_sel = 1'b1; host_addr = 7'd0;
            #1 chk1("clr_host_stall", host_stall, 1'b1);
            host_re = 1'b0;
         end
         tick();
      end
      chk1("clr_finished", done, 1'b1);
      chk32("clr_busy_cycles", busy_n, 32'd129);
      chk1("clr_err", err, 1'b0);
      for (int i = 0; i < 128; i++) begin
         host_re = 1'b1; host_sel = 1'b1; host_addr = 7'(i);
         tick();
         host_re = 1'b0;
         chk32($sformatf("clr_dir%0d", i), host_rdata, 32'h0);
      end

      // Reset mid-operation: in-flight read and clear are abandoned
      host_re = 1'b1; host_sel = 1'b0; host_addr = 7'd0;
      tick();
      host_re = 1'b0;
      chk32("pre_rst_hrd", host_rdata, 32'h76543210);
      host_clr_dir = 1'b1;
      tick();
      host_clr_dir = 1'b0;
      req_rd = 1'b1; addr_rd = 32'h40000004;
      tick();
      req_rd = 1'b0;
      chk1("pre_rst_busy", busy, 1'b1);
      #1 arst_n = 1'b0;
      #1 chk_reset_outputs("arst");
      tick();
      arst_n = 1'b1;
      rdy_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         rdy_seen = rdy_seen | data_rdy;
      end
      chk1("post_rst_no_rdy", rdy_seen, 1'b0);
      chk_reset_outputs("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
